fpu_issue: RTL

Initiator side of the FPU request/ready–result/valid handshake. Accepts FP operations from the core's decode stage into a 2-entry request queue, and presents the head entry to the FPU. It holds operands stable until the FPU signals completion, then registers the result as a one-cycle write-back to the FP register file or the FP condition flag. Sits between decode/regfile-read and the FPU arithmetic unit, and provides back-pressure, flush and a hang watchdog.

---
 rtl/fpu_issue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fpu_issue.sv
// fpu_issue: two-entry request queue that presents FP ops to the FPU, holds them
// until completion and registers the result as a one-cycle write-back.
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 5
`endif

module fpu_issue #(
  parameter int OP_W = `FPU_OP_WIDTH,
  parameter int TMO  = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [4:0]      in_rd,
  input  logic            in_flag,
  input  logic            flush,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  output logic [OP_W-1:0] fpu_op,
  output logic            fpu_ready,
  input  logic            fpu_valid,
  input  logic [31:0]     fpu_y32,
  input  logic            fpu_y1,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_flag,
  output logic            wb_y1,
  output logic            busy,
  output logic            err_tmo
);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     x1;
    logic [31:0]     x2;
    logic [4:0]      rd;
    logic            flag;
  } entry_t;

  // S_DRAIN: head was flushed but the FPU must still finish it; its result is dropped.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  state_e      state_q, state_d;
  entry_t      slot_q [2];
  entry_t      slot_d [2];
  entry_t      inEntry;
  logic [1:0]  count_q, count_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        err_q, err_d;
  logic        wbValid_q, wbValid_d;
  logic [4:0]  wbRd_q;
  logic [31:0] wbData_q;
  logic        wbFlag_q;
  logic        wbY1_q;
  logic        push, pop;

  assign inEntry   = '{op: in_op, x1: in_x1, x2: in_x2, rd: in_rd, flag: in_flag};
  assign in_ready  = (count_q != 2'd2) && (state_q != S_DRAIN);
  assign fpu_ready = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = fpu_valid && fpu_ready;

  assign fpu_op = fpu_ready ? slot_q[0].op : '0;
  assign fpu_x1 = fpu_ready ? slot_q[0].x1 : '0;
  assign fpu_x2 = fpu_ready ? slot_q[0].x2 : '0;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (pop) begin
      slot_d[0] = slot_q[1];
      count_d   = count_q - 2'd1;
    end
    // Flush keeps only an unfinished head; anything behind it is dropped.
    if (flush) begin
      count_d = (count_q != 2'd0 && !pop) ? 2'd1 : 2'd0;
    end
    if (push) begin
      slot_d[count_d[0]] = inEntry;
      count_d            = count_d + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (count_d == 2'd0) begin
      state_d = S_IDLE;
    end else if (flush && !pop) begin
      state_d = S_DRAIN;
    end else if (state_q == S_IDLE || pop) begin
      state_d = S_WAIT;
    end
  end

  always_comb begin
    wbValid_d = pop && !flush && (state_q != S_DRAIN);
    wdog_d    = wdog_q;
    err_d     = err_q;
    if (!fpu_ready || fpu_valid) begin
      wdog_d = '0;
    end else if (wdog_q != 8'hFF) begin
      wdog_d = wdog_q + 8'd1;
    end
    if (wdog_d == 8'(TMO)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      wbValid_q <= 1'b0;
      wbRd_q    <= '0;
      wbData_q  <= '0;
      wbFlag_q  <= 1'b0;
      wbY1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      slot_q    <= slot_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      wbValid_q <= wbValid_d;
      if (pop) begin
        wbRd_q   <= slot_q[0].rd;
        wbData_q <= fpu_y32;
        wbFlag_q <= slot_q[0].flag;
        wbY1_q   <= fpu_y1;
      end
    end
  end

  assign wb_valid = wbValid_q;
  assign wb_rd    = wbRd_q;
  assign wb_data  = wbData_q;
  assign wb_flag  = wbFlag_q;
  assign wb_y1    = wbY1_q;
  assign busy     = fpu_ready || wbValid_q;
  assign err_tmo  = err_q;

endmodule
